// File: rtl/order_book_if.sv
// Order-entry and trade-report handshake bundle for the order book matcher.
// The master side is upstream order flow plus the trade consumer; the slave side is the matcher.
interface order_book_if #(
  parameter int PW = 8,
  parameter int QW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic          in_side;
  logic [PW-1:0] in_price;
  logic [QW-1:0] in_qty;
  logic          trade_valid;
  logic          trade_ready;
  logic [PW-1:0] trade_price;
  logic [QW-1:0] trade_qty;

  modport master (
    output in_valid, in_side, in_price, in_qty, trade_ready,
    input  in_ready, trade_valid, trade_price, trade_qty
  );

  modport slave (
    input  in_valid, in_side, in_price, in_qty, trade_ready,
    output in_ready, trade_valid, trade_price, trade_qty
  );
endinterface

// File: rtl/order_book_matcher.sv
// Two-sided limit order book with price/time priority matching and a
// back-pressured trade report stream. Side index 0 = buy, 1 = sell.
module order_book_matcher #(
  parameter int PW    = 8,
  parameter int QW    = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  order_book_if.slave                ob,
  output logic [PW-1:0]              best_bid,
  output logic [PW-1:0]              best_ask,
  output logic [$clog2(DEPTH+1)-1:0] bid_count,
  output logic [$clog2(DEPTH+1)-1:0] ask_count,
  output logic                       reject,
  output logic [15:0]                trade_count
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, MATCH, EMIT} state_t;

  state_t        state_reg;
  logic [PW-1:0] price_reg [2][DEPTH];
  logic [QW-1:0] qty_reg   [2][DEPTH];
  logic [CW-1:0] cnt_reg   [2];
  logic          trade_valid_reg;
  logic [PW-1:0] trade_price_reg;
  logic [QW-1:0] trade_qty_reg;
  logic          reject_reg;
  logic [15:0]   trade_count_reg;

  logic [PW-1:0] top_price [2];
  logic [QW-1:0] top_qty   [2];
  logic [IW-1:0] top_idx   [2];
  logic [PW-1:0] up_price  [2][DEPTH];
  logic [QW-1:0] up_qty    [2][DEPTH];
  logic          crossed;
  logic [QW-1:0] match_qty;
  logic [PW:0]   mid_sum;
  logic          remove    [2];

  // Each slot's neighbour from above, used when an exhausted entry is squeezed out.
  for (genvar gs = 0; gs < 2; gs++) begin : g_side
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      if (gi < DEPTH-1) begin : g_up
        assign up_price[gs][gi] = price_reg[gs][gi+1];
        assign up_qty[gs][gi]   = qty_reg[gs][gi+1];
      end else begin : g_top
        assign up_price[gs][gi] = '0;
        assign up_qty[gs][gi]   = '0;
      end
    end
  end

  // Valid slots are contiguous from 0, so slot 0 seeds the search; strict compares keep the oldest on ties.
  always_comb begin
    top_price[0] = '0;
    top_price[1] = '1;
    top_qty[0]   = '0;
    top_qty[1]   = '0;
    top_idx[0]   = '0;
    top_idx[1]   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i < int'(cnt_reg[0]) && (i == 0 || price_reg[0][i] > top_price[0])) begin
        top_price[0] = price_reg[0][i];
        top_qty[0]   = qty_reg[0][i];
        top_idx[0]   = IW'(i);
      end
      if (i < int'(cnt_reg[1]) && (i == 0 || price_reg[1][i] < top_price[1])) begin
        top_price[1] = price_reg[1][i];
        top_qty[1]   = qty_reg[1][i];
        top_idx[1]   = IW'(i);
      end
    end
  end

  assign crossed   = (cnt_reg[0] != '0) && (cnt_reg[1] != '0) && (top_price[0] >= top_price[1]);
  assign match_qty = (top_qty[0] < top_qty[1]) ? top_qty[0] : top_qty[1];
  assign mid_sum   = {1'b0, top_price[0]} + {1'b0, top_price[1]};
  assign remove[0] = (top_qty[0] == match_qty);
  assign remove[1] = (top_qty[1] == match_qty);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      trade_valid_reg <= 1'b0;
      trade_price_reg <= '0;
      trade_qty_reg   <= '0;
      reject_reg      <= 1'b0;
      trade_count_reg <= '0;
      for (int s = 0; s < 2; s++) begin
        cnt_reg[s] <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          price_reg[s][i] <= '0;
          qty_reg[s][i]   <= '0;
        end
      end
    end else begin
      reject_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (ob.in_valid && ob.in_qty != '0) begin
            if (cnt_reg[ob.in_side] == CW'(DEPTH)) begin
              reject_reg <= 1'b1;
            end else begin
              for (int i = 0; i < DEPTH; i++) begin
                if (i == int'(cnt_reg[ob.in_side])) begin
                  price_reg[ob.in_side][i] <= ob.in_price;
                  qty_reg[ob.in_side][i]   <= ob.in_qty;
                end
              end
              cnt_reg[ob.in_side] <= cnt_reg[ob.in_side] + 1'b1;
              state_reg           <= MATCH;
            end
          end
        end
        MATCH: begin
          if (crossed) begin
            trade_valid_reg <= 1'b1;
            trade_price_reg <= mid_sum[PW:1];
            trade_qty_reg   <= match_qty;
            state_reg       <= EMIT;
            for (int s = 0; s < 2; s++) begin
              for (int i = 0; i < DEPTH; i++) begin
                if (remove[s] && i >= int'(top_idx[s])) begin
                  price_reg[s][i] <= up_price[s][i];
                  qty_reg[s][i]   <= up_qty[s][i];
                end else if (i == int'(top_idx[s])) begin
                  qty_reg[s][i] <= top_qty[s] - match_qty;
                end
              end
              if (remove[s]) cnt_reg[s] <= cnt_reg[s] - 1'b1;
            end
          end else begin
            state_reg <= IDLE;
          end
        end
        EMIT: begin
          if (ob.trade_ready) begin
            trade_valid_reg <= 1'b0;
            if (trade_count_reg != 16'hFFFF) trade_count_reg <= trade_count_reg + 16'd1;
            state_reg <= MATCH;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ob.in_ready    = (state_reg == IDLE);
  assign ob.trade_valid = trade_valid_reg;
  assign ob.trade_price = trade_price_reg;
  assign ob.trade_qty   = trade_qty_reg;
  assign best_bid       = top_price[0];
  assign best_ask       = top_price[1];
  assign bid_count      = cnt_reg[0];
  assign ask_count      = cnt_reg[1];
  assign reject         = reject_reg;
  assign trade_count    = trade_count_reg;
endmodule

// File: tb/tb_order_book_matcher.sv
// Directed scenarios for order_book_matcher; trades are checked by a queue-based
// monitor independent of the stimulus thread.
module tb_order_book_matcher;
  localparam int PW = 8;
  localparam int QW = 8;
  localparam int DEPTH = 8;

  typedef struct {
    logic [PW-1:0] price;
    logic [QW-1:0] qty;
  } trade_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [PW-1:0] best_bid;
  logic [PW-1:0] best_ask;
  logic [3:0]    bid_count;
  logic [3:0]    ask_count;
  logic          reject;
  logic [15:0]   trade_count;

  trade_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  order_book_if #(.PW(PW), .QW(QW)) ob ();

  order_book_matcher #(.PW(PW), .QW(QW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .ob          (ob),
    .best_bid    (best_bid),
    .best_ask    (best_ask),
    .bid_count   (bid_count),
    .ask_count   (ask_count),
    .reject      (reject),
    .trade_count (trade_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Handshake happens on the following rising edge, so the pop and compare happen here.
  always @(negedge clk) begin : monitor
    trade_t e;
    if (!reset && ob.trade_valid && ob.trade_ready) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_trade: got price %0d qty %0d expected none", ob.trade_price, ob.trade_qty);
      end else begin
        e = sb.pop_front();
        check("trade_price", int'(ob.trade_price), int'(e.price));
        check("trade_qty", int'(ob.trade_qty), int'(e.qty));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_trade(input int price, input int qty);
    trade_t t;
    t.price = PW'(price);
    t.qty   = QW'(qty);
    sb.push_back(t);
  endtask

  task automatic send(input logic side, input int price, input int qty);
    int n = 0;
    while (!ob.in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!ob.in_ready) timeout("send_in_ready");
    ob.in_valid = 1'b1;
    ob.in_side  = side;
    ob.in_price = PW'(price);
    ob.in_qty   = QW'(qty);
    tick();
    ob.in_valid = 1'b0;
    $display("order side=%0d price=%0d qty=%0d", side, price, qty);
  endtask

  task automatic wait_idle();
    int n = 0;
    tick();
    while (!(ob.in_ready && !ob.trade_valid) && n < 200) begin
      tick();
      n++;
    end
    if (!(ob.in_ready && !ob.trade_valid)) timeout("wait_idle");
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sb.delete();
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int n;
    ob.in_valid    = 1'b0;
    ob.in_side     = 1'b0;
    ob.in_price    = '0;
    ob.in_qty      = '0;
    ob.trade_ready = 1'b1;
    reset          = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();

    check("rst_trade_valid", int'(ob.trade_valid), 0);
    check("rst_bid_count", int'(bid_count), 0);
    check("rst_ask_count", int'(ask_count), 0);
    check("rst_best_bid", int'(best_bid), 0);
    check("rst_best_ask", int'(best_ask), 255);
    check("rst_trade_count", int'(trade_count), 0);
    check("rst_in_ready", int'(ob.in_ready), 1);

    // Partial fill at the midpoint, leftover bid verified by a second fill.
    send(1'b0, 100, 5);
    wait_idle();
    expect_trade(99, 3);
    send(1'b1, 98, 3);
    wait_idle();
    check("p1_bid_count", int'(bid_count), 1);
    check("p1_best_bid", int'(best_bid), 100);
    check("p1_ask_count", int'(ask_count), 0);
    check("p1_best_ask", int'(best_ask), 255);
    check("p1_trade_count", int'(trade_count), 1);
    expect_trade(100, 2);
    send(1'b1, 100, 2);
    wait_idle();
    check("p1b_bid_count", int'(bid_count), 0);
    check("p1b_trade_count", int'(trade_count), 2);

    // Time priority among equal bids.
    do_reset();
    send(1'b0, 100, 2);
    wait_idle();
    send(1'b0, 100, 4);
    wait_idle();
    expect_trade(100, 2);
    expect_trade(100, 1);
    send(1'b1, 100, 3);
    wait_idle();
    check("tp_bid_count", int'(bid_count), 1);
    check("tp_ask_count", int'(ask_count), 0);
    check("tp_trade_count", int'(trade_count), 2);
    expect_trade(95, 3);
    send(1'b1, 90, 3);
    wait_idle();
    check("tp_bid_empty", int'(bid_count), 0);
    check("tp_trade_count2", int'(trade_count), 3);

    // Full side rejects, zero quantity is dropped silently.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      send(1'b0, 10, 1);
      wait_idle();
    end
    check("full_bid_count", int'(bid_count), 8);
    send(1'b0, 10, 1);
    check("full_reject_pulse", int'(reject), 1);
    check("full_bid_count2", int'(bid_count), 8);
    check("full_in_ready", int'(ob.in_ready), 1);
    tick();
    check("full_reject_clear", int'(reject), 0);
    send(1'b1, 200, 0);
    check("zero_qty_reject", int'(reject), 0);
    check("zero_qty_ask_count", int'(ask_count), 0);
    check("zero_qty_in_ready", int'(ob.in_ready), 1);

    // Back-pressure: trade held five cycles, accepted on the sixth.
    do_reset();
    ob.trade_ready = 1'b0;
    send(1'b0, 70, 2);
    wait_idle();
    expect_trade(65, 2);
    send(1'b1, 60, 2);
    n = 0;
    while (!ob.trade_valid && n < 50) begin
      tick();
      n++;
    end
    if (!ob.trade_valid) timeout("stall_trade_valid");
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", int'(ob.trade_valid), 1);
      check("stall_price", int'(ob.trade_price), 65);
      check("stall_qty", int'(ob.trade_qty), 2);
      check("stall_in_ready", int'(ob.in_ready), 0);
      tick();
    end
    ob.trade_ready = 1'b1;
    wait_idle();
    check("stall_trade_count", int'(trade_count), 1);
    check("stall_bid_count", int'(bid_count), 0);

    // Sell rests first, then an aggressive buy empties both sides.
    send(1'b1, 50, 4);
    wait_idle();
    expect_trade(55, 4);
    send(1'b0, 60, 4);
    wait_idle();
    check("sb_bid_count", int'(bid_count), 0);
    check("sb_ask_count", int'(ask_count), 0);
    check("sb_in_ready", int'(ob.in_ready), 1);
    check("sb_trade_count", int'(trade_count), 2);
    check("sb_best_ask", int'(best_ask), 255);

    // Asynchronous reset while a trade is pending in EMIT.
    ob.trade_ready = 1'b0;
    send(1'b0, 30, 1);
    wait_idle();
    send(1'b1, 20, 1);
    n = 0;
    while (!ob.trade_valid && n < 50) begin
      tick();
      n++;
    end
    check("pre_reset_valid", int'(ob.trade_valid), 1);
    #1;
    reset = 1'b1;
    #1;
    check("ar_trade_valid", int'(ob.trade_valid), 0);
    check("ar_bid_count", int'(bid_count), 0);
    check("ar_ask_count", int'(ask_count), 0);
    check("ar_best_bid", int'(best_bid), 0);
    check("ar_best_ask", int'(best_ask), 255);
    check("ar_trade_count", int'(trade_count), 0);
    sb.delete();
    tick();
    reset = 1'b0;
    ob.trade_ready = 1'b1;
    tick();
    check("ar_in_ready", int'(ob.in_ready), 1);

    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
